data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store stage and datamemory.
//  Refills a whole line in one capture from the memory's block-wide read port (2**BLOCK_SIZE words).
//  Hits return data in the same cycle with no stall. Misses stall the CPU for FILL_LATENCY+1 cycles.
// PARAMETERS
//  DATA_WIDTH     32  word width
//  ADDRESS_WIDTH  30  word address width; must match datamemory
//  BLOCK_SIZE     3   log2 words per line; must match datamemory
//  INDEX_BITS     4   log2 number of lines (16)
//  FILL_LATENCY   2   cycles the FSM spends in FILL; must be >= 1
// PORTS
//  clk               in   1                        clock; all state updates on posedge
//  rst_n             in   1                        asynchronous active-low reset
//  cpu_address       in   ADDRESS_WIDTH            word address of the access
//  cpu_write_data    in   DATA_WIDTH               store data
//  cpu_read_en       in   1                        load request
//  cpu_write_en      in   1                        store request
//  cpu_read_data     out  DATA_WIDTH               load data; valid when cpu_read_en & ~stall
//  stall             out  1                        CPU must hold all cpu_* inputs stable while this is 1
//  mem_address       out  ADDRESS_WIDTH            to datamemory address
//  mem_write_data    out  DATA_WIDTH               to datamemory write_data
//  mem_write_enable  out  1                        to datamemory write_enable
//  mem_read_block    in   2**BLOCK_SIZE*DATA_WIDTH packed block from datamemory; word i = words [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Address split: offset=[BLOCK_SIZE-1:0], index=[BLOCK_SIZE+INDEX_BITS-1:BLOCK_SIZE], tag=remaining upper bits.
//  hit = valid[index] & (tag_q[index]==tag). cpu_read_data = line[index][offset] on a hit, else 0.
//  Reset (rst_n low, async): state=IDLE, fill counter=0, all valid bits=0.
//   While in reset, stall=0, mem_write_enable=0 and cpu_read_data=0. Tag and data arrays are not reset.
//  FSM states: IDLE, FILL.
//  IDLE:
//   cpu_write_en=1 is a store; a store wins if cpu_read_en is also 1. A store never stalls.
//    mem_write_enable=1 and mem_write_data=cpu_write_data, so memory is written on the next negedge.
//    Store hit: line word [index][offset] updated at posedge.
//    Store miss: cache unchanged (no allocate).
//   cpu_read_en=1 and hit: stall=0, data returned combinationally.
//   cpu_read_en=1 and miss: stall=1; capture fill address; counter<=0; go to FILL.
//   Otherwise: stall=0, no state change.
//  FILL:
//   stall=1, mem_write_enable=0, mem_address=captured address; counter increments each cycle.
//   On the cycle with counter==FILL_LATENCY-1, at posedge:
//    all 2**BLOCK_SIZE words load from mem_read_block into line[index];
//    tag_q[index]<=tag and valid[index]<=1; go to IDLE.
//   The load then hits in IDLE: total stall is FILL_LATENCY+1 cycles.
//  mem_address = cpu_address in IDLE, captured address in FILL.
//  A refill overwrites whatever line occupies the index; write-through means no writeback is ever needed.
//  cpu_write_en asserted during FILL is ignored; it is only legal after stall drops.
//  rst_n asserted mid-FILL aborts the refill. The line stays invalid and stall drops immediately.
//  No X may appear on any output after reset while the inputs are known.
// STRUCTURE
//  Package cache_pkg holds:
//   typedef enum logic {IDLE, FILL} cache_state_t;
//   localparam-derived TAG_BITS;
//   functions get_tag, get_index and get_offset.
//  Sub-module data_cache_array holds the tag, valid and data arrays.
//   Interfaces: read port (index); line-write port (index, tag, block); word-write port (index, offset, data); async valid clear.
//  The top level holds the FSM, fill counter, hit compare and memory-side muxing.
// TESTING (defaults; memory preloaded with mem[a]=a^32'hA5A5_0000)
//  1 Cold load: reset, read 0x040 -> stall=1 for 3 cycles, then cpu_read_data=0xA5A5_0040, stall=0.
//    Then read 0x047 -> stall=0 in the same cycle, data=0xA5A5_0047.
//  2 Conflict: load 0x000 then 0x080 (same index 0, tag 1) -> both miss with 3-cycle stall.
//    Re-read 0x000 -> misses again, returns 0xA5A5_0000.
//  3 Store hit: after test 1, write 0xDEADBEEF to 0x042 -> stall=0, mem_write_enable=1, mem_address=0x042.
//    Next read of 0x042 -> hit, returns 0xDEADBEEF.
//  4 Store miss: write 0x12345678 to 0x100 (uncached) -> stall=0, memory written, valid bits unchanged.
//    Read 0x100 -> 3-cycle miss, returns 0x12345678.
//  5 Reset mid-fill: pull rst_n low in the 2nd FILL cycle -> stall=0 immediately.
//    After release, reading the same address takes the full 3-cycle miss.
//  6 Simultaneous cpu_read_en & cpu_write_en on a cached 0x041 with data 0x0BADF00D -> store, no stall.
//    Line and memory both hold 0x0BADF00D.

Source files
------------

// File: rtl/data_cache_pkg.sv
// cache_pkg: geometry constants, FSM state type and address-split helpers for data_cache.
package cache_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 30;
  localparam int BLOCK_SIZE    = 3;
  localparam int INDEX_BITS    = 4;
  localparam int TAG_BITS      = ADDRESS_WIDTH - BLOCK_SIZE - INDEX_BITS;
  localparam int BLOCK_BITS    = DATA_WIDTH << BLOCK_SIZE;
  localparam int LINES         = 1 << INDEX_BITS;
  typedef enum logic {IDLE, FILL} cache_state_t;
  function automatic logic [TAG_BITS-1:0] get_tag(input logic [ADDRESS_WIDTH-1:0] a);
    return a[ADDRESS_WIDTH-1 -: TAG_BITS];
  endfunction
  function automatic logic [INDEX_BITS-1:0] get_index(input logic [ADDRESS_WIDTH-1:0] a);
    return a[BLOCK_SIZE +: INDEX_BITS];
  endfunction
  function automatic logic [BLOCK_SIZE-1:0] get_offset(input logic [ADDRESS_WIDTH-1:0] a);
    return a[BLOCK_SIZE-1:0];
  endfunction
endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: CPU-side and datamemory-side signals of the data cache.
interface data_cache_if;
  import cache_pkg::*;
  logic [ADDRESS_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0]    cpu_write_data;
  logic                     cpu_read_en;
  logic                     cpu_write_en;
  logic [DATA_WIDTH-1:0]    cpu_read_data;
  logic                     stall;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_write_data;
  logic                     mem_write_enable;
  logic [BLOCK_BITS-1:0]    mem_read_block;
  modport master (
    output cpu_address, cpu_write_data, cpu_read_en, cpu_write_en, mem_read_block,
    input  cpu_read_data, stall, mem_address, mem_write_data, mem_write_enable
  );
  modport slave (
    input  cpu_address, cpu_write_data, cpu_read_en, cpu_write_en, mem_read_block,
    output cpu_read_data, stall, mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/data_cache_array.sv
// data_cache_array: tag, valid and data storage; whole-line refill port and single-word store port.
module data_cache_array
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_valid,
  output logic [BLOCK_BITS-1:0] rd_line,
  input  logic                  line_we,
  input  logic [INDEX_BITS-1:0] line_index,
  input  logic [TAG_BITS-1:0]   line_tag,
  input  logic [BLOCK_BITS-1:0] line_block,
  input  logic                  word_we,
  input  logic [INDEX_BITS-1:0] word_index,
  input  logic [BLOCK_SIZE-1:0] word_offset,
  input  logic [DATA_WIDTH-1:0] word_data
);
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [BLOCK_BITS-1:0] data_q [LINES];
  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (line_we) valid_q[line_index] <= 1'b1;
  // Tags and data are deliberately left unreset; valid gates every use of them.
  always_ff @(posedge clk)
    if (line_we) begin
      tag_q[line_index]  <= line_tag;
      data_q[line_index] <= line_block;
    end else if (word_we) data_q[word_index][word_offset*DATA_WIDTH +: DATA_WIDTH] <= word_data;
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Hits answer combinationally; a load miss stalls for FILL_LATENCY+1 cycles while a line is refilled.
module data_cache
  import cache_pkg::*;
#(
  parameter int FILL_LATENCY = 2
) (
  input logic         clk,
  input logic         rst_n,
  data_cache_if.slave bus
);
  localparam int CW = $clog2(FILL_LATENCY + 1);
  cache_state_t             state;
  logic [CW-1:0]            cnt;
  logic [ADDRESS_WIDTH-1:0] fill_addr;
  logic [TAG_BITS-1:0]      rd_tag;
  logic                     rd_valid;
  logic [BLOCK_BITS-1:0]    rd_line;
  logic                     hit, store, miss_rd, last;
  assign hit     = rd_valid && rd_tag == get_tag(bus.cpu_address);
  assign store   = state == IDLE && bus.cpu_write_en;
  assign miss_rd = state == IDLE && !bus.cpu_write_en && bus.cpu_read_en && !hit;
  assign last    = state == FILL && cnt == CW'(FILL_LATENCY - 1);
  assign bus.cpu_read_data    = hit ? rd_line[get_offset(bus.cpu_address)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.stall            = rst_n && (state == FILL || miss_rd);
  assign bus.mem_write_enable = rst_n && store;
  assign bus.mem_write_data   = bus.cpu_write_data;
  assign bus.mem_address      = state == FILL ? fill_addr : bus.cpu_address;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_addr <= '0;
    end else if (state == IDLE) begin
      if (miss_rd) begin
        state     <= FILL;
        cnt       <= '0;
        fill_addr <= bus.cpu_address;
      end
    end else begin
      cnt <= cnt + 1'b1;
      if (last) state <= IDLE;
    end
  data_cache_array u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_index    (get_index(bus.cpu_address)),
    .rd_tag      (rd_tag),
    .rd_valid    (rd_valid),
    .rd_line     (rd_line),
    .line_we     (last),
    .line_index  (get_index(fill_addr)),
    .line_tag    (get_tag(fill_addr)),
    .line_block  (bus.mem_read_block),
    .word_we     (store && hit),
    .word_index  (get_index(bus.cpu_address)),
    .word_offset (get_offset(bus.cpu_address)),
    .word_data   (bus.cpu_write_data)
  );
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed checks of data_cache against a block-read memory model.
module tb_data_cache;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int fails = 0;
  logic [31:0] mem [1024];
  logic [255:0] blk;
  data_cache_if bus();
  data_cache dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_read_block = blk;
  always_comb begin
    blk = '0;
    for (int i = 0; i < 8; i++) blk[i*32 +: 32] = mem[{bus.mem_address[9:3], 3'(i)}];
  end
  always @(negedge clk) if (bus.mem_write_enable) mem[bus.mem_address[9:0]] = bus.mem_write_data;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [29:0] a, input logic [31:0] exp, input int exp_st, input string tag);
    int n = 0;
    bus.cpu_address = a; bus.cpu_read_en = 1; bus.cpu_write_en = 0;
    #2;
    while (bus.stall && n < 20) begin
      n++;
      @(posedge clk); #3;
    end
    chk(n, exp_st, {tag, " stall cycles"});
    chk(bus.cpu_read_data, exp, {tag, " data"});
    @(posedge clk); #1;
    bus.cpu_read_en = 0;
  endtask

  task automatic store(input logic [29:0] a, input logic [31:0] d, input logic rd, input string tag);
    bus.cpu_address = a; bus.cpu_write_data = d; bus.cpu_write_en = 1; bus.cpu_read_en = rd;
    #2;
    chk(bus.stall, 0, {tag, " stall"});
    chk(bus.mem_write_enable, 1, {tag, " mem_we"});
    chk(bus.mem_address, 32'(a), {tag, " mem_addr"});
    chk(bus.mem_write_data, d, {tag, " mem_wdata"});
    @(posedge clk); #1;
    bus.cpu_write_en = 0; bus.cpu_read_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) ^ 32'hA5A5_0000;
    bus.cpu_address = 30'h040; bus.cpu_write_data = 32'h0; bus.cpu_read_en = 1; bus.cpu_write_en = 1;
    @(posedge clk); #1;
    chk(bus.stall, 0, "reset stall");
    chk(bus.mem_write_enable, 0, "reset mem_we");
    chk(bus.cpu_read_data, 0, "reset rdata");
    bus.cpu_write_en = 0; bus.cpu_read_en = 0;
    @(posedge clk); #1;
    rst_n = 1;
    // cold load then same-line hit
    load(30'h040, 32'hA5A5_0040, 3, "cold 040");
    load(30'h047, 32'hA5A5_0047, 0, "hit 047");
    // conflict on index 0
    load(30'h000, 32'hA5A5_0000, 3, "miss 000");
    load(30'h080, 32'hA5A5_0080, 3, "miss 080");
    load(30'h000, 32'hA5A5_0000, 3, "remiss 000");
    // store hit
    store(30'h042, 32'hDEADBEEF, 0, "store hit 042");
    load(30'h042, 32'hDEADBEEF, 0, "read 042");
    chk(mem[10'h042], 32'hDEADBEEF, "mem 042");
    // store miss leaves index 0 line (address 0x000) intact
    store(30'h100, 32'h12345678, 0, "store miss 100");
    chk(mem[10'h100], 32'h12345678, "mem 100");
    load(30'h000, 32'hA5A5_0000, 0, "still hit 000");
    load(30'h100, 32'h12345678, 3, "read 100");
    // reset in second fill cycle
    bus.cpu_address = 30'h200; bus.cpu_read_en = 1;
    #2;
    chk(bus.stall, 1, "miss 200 stall");
    @(posedge clk); #3;
    chk(bus.mem_address, 32'h200, "fill mem_addr");
    chk(bus.mem_write_enable, 0, "fill mem_we");
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk(bus.stall, 0, "reset mid-fill stall");
    @(posedge clk); #1;
    rst_n = 1;
    load(30'h200, 32'hA5A5_0200, 3, "after abort 200");
    load(30'h047, 32'hA5A5_0047, 3, "invalidated 047");
    // simultaneous read and write: store wins
    load(30'h041, 32'hA5A5_0041, 0, "hit 041");
    store(30'h041, 32'h0BADF00D, 1, "rw 041");
    load(30'h041, 32'h0BADF00D, 0, "read 041");
    chk(mem[10'h041], 32'h0BADF00D, "mem 041");
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
